// File: rtl/open_loop_rx_flow_q.sv
`timescale 1ns/1ps
// open_loop_rx_flow_q: flow-ID work queue feeding the open-loop RX engine; registers NUM_FLOWS IDs
// during setup, then serves them round-robin. Defining OPEN_LOOP_RX_FLOWQ_STATS_EN adds hwm/pop/ovf stats.
module open_loop_rx_flow_q #(
  parameter int DEPTH     = 64,
  parameter int NUM_FLOWS = 16,
  parameter int FLOWID_W  = 16,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                setup_flowq_val,
  input  logic [FLOWID_W-1:0] setup_flowq_flowid,
  output logic                flowq_setup_rdy,
  output logic                recv_q_empty,
  output logic [FLOWID_W-1:0] recv_q_rd_data,
  input  logic                recv_q_rd_req,
  output logic                recv_q_full,
  input  logic                recv_q_wr_req,
  input  logic [FLOWID_W-1:0] recv_q_wr_data,
  output logic                setup_done,
`ifdef OPEN_LOOP_RX_FLOWQ_STATS_EN
  output logic [PTR_W:0]      flowq_hwm,
  output logic [31:0]         flowq_pop_cnt,
  output logic                flowq_ovf,
`endif
  output logic [PTR_W:0]      flowq_occupancy
);

  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_SETUP = 1'b0, ST_DONE = 1'b1} state_t;

  generate
    if (NUM_FLOWS < 1 || NUM_FLOWS > DEPTH) begin : g_bad_num_flows
      $error("open_loop_rx_flow_q: NUM_FLOWS must be in 1..DEPTH");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("open_loop_rx_flow_q: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [FLOWID_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    reg_cnt_q;
  logic                empty_q, full_q;
  logic                setup_done_q;
  state_t              state_q;

  logic                rx_wr_acc, setup_acc, wr_acc, rd_acc;
  logic [FLOWID_W-1:0] wr_data;

  // RX requeue wins; setup is only offered a slot when the RX engine is not writing.
  always_comb begin
    flowq_setup_rdy = !rst && (state_q == ST_SETUP) && !full_q && !recv_q_wr_req;
    rx_wr_acc       = recv_q_wr_req && !full_q;
    setup_acc       = setup_flowq_val && flowq_setup_rdy;
    wr_acc          = rx_wr_acc || setup_acc;
    wr_data         = rx_wr_acc ? recv_q_wr_data : setup_flowq_flowid;
    rd_acc          = recv_q_rd_req && !empty_q;
    count_d         = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SETUP;
      setup_done_q <= 1'b0;
      reg_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_SETUP: begin
          if (setup_acc) begin
            reg_cnt_q <= reg_cnt_q + CNT_W'(1);
            if (reg_cnt_q == CNT_W'(NUM_FLOWS - 1)) begin
              state_q      <= ST_DONE;
              setup_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= ST_DONE;
          setup_done_q <= 1'b1;
        end
      endcase
    end
  end

  assign recv_q_empty    = empty_q;
  assign recv_q_full     = full_q;
  assign recv_q_rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign setup_done      = setup_done_q;
  assign flowq_occupancy = count_q;

`ifdef OPEN_LOOP_RX_FLOWQ_STATS_EN
  logic [CNT_W-1:0] hwm_q;
  logic [31:0]      pop_cnt_q;
  logic             ovf_q;

  // hwm tracks count_d so it rises in the same cycle the occupancy does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm_q     <= '0;
      pop_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (count_d > hwm_q) hwm_q <= count_d;
      if (rd_acc && (pop_cnt_q != '1)) pop_cnt_q <= pop_cnt_q + 32'd1;
      if (recv_q_wr_req && full_q) ovf_q <= 1'b1;
    end
  end

  assign flowq_hwm     = hwm_q;
  assign flowq_pop_cnt = pop_cnt_q;
  assign flowq_ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_open_loop_rx_flow_q.sv
`timescale 1ns/1ps
// Directed bench for open_loop_rx_flow_q with DEPTH=8, NUM_FLOWS=4, 8-bit flow IDs.
module tb_open_loop_rx_flow_q;

  logic       clk;
  logic       rst;
  logic       setup_flowq_val;
  logic [7:0] setup_flowq_flowid;
  logic       flowq_setup_rdy;
  logic       recv_q_empty;
  logic [7:0] recv_q_rd_data;
  logic       recv_q_rd_req;
  logic       recv_q_full;
  logic       recv_q_wr_req;
  logic [7:0] recv_q_wr_data;
  logic       setup_done;
  logic [3:0] flowq_occupancy;
`ifdef OPEN_LOOP_RX_FLOWQ_STATS_EN
  logic [3:0]  flowq_hwm;
  logic [31:0] flowq_pop_cnt;
  logic        flowq_ovf;
`endif

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [7:0] model[$];

  open_loop_rx_flow_q #(.DEPTH(8), .NUM_FLOWS(4), .FLOWID_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .setup_flowq_val(setup_flowq_val),
    .setup_flowq_flowid(setup_flowq_flowid),
    .flowq_setup_rdy(flowq_setup_rdy),
    .recv_q_empty(recv_q_empty),
    .recv_q_rd_data(recv_q_rd_data),
    .recv_q_rd_req(recv_q_rd_req),
    .recv_q_full(recv_q_full),
    .recv_q_wr_req(recv_q_wr_req),
    .recv_q_wr_data(recv_q_wr_data),
    .setup_done(setup_done),
`ifdef OPEN_LOOP_RX_FLOWQ_STATS_EN
    .flowq_hwm(flowq_hwm),
    .flowq_pop_cnt(flowq_pop_cnt),
    .flowq_ovf(flowq_ovf),
`endif
    .flowq_occupancy(flowq_occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    setup_flowq_val = 1'b0;
    recv_q_rd_req = 1'b0;
    recv_q_wr_req = 1'b0;
    step();
    rst = 1'b0;
    pops = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setup_flowq_val = 1'b1;
    setup_flowq_flowid = 8'd0;
    recv_q_rd_req = 1'b0;
    recv_q_wr_req = 1'b0;
    recv_q_wr_data = 8'd0;
    #2;
    checks++; if (recv_q_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", recv_q_empty); end
    checks++; if (recv_q_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", recv_q_full); end
    checks++; if (setup_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", setup_done); end
    checks++; if (flowq_setup_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", flowq_setup_rdy); end
    checks++; if (flowq_occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", flowq_occupancy); end
    checks++; if (recv_q_rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd_data got=%0d exp=0", recv_q_rd_data); end
    setup_flowq_val = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_setup();
    for (int i = 0; i < 4; i++) begin
      setup_flowq_val = 1'b1;
      setup_flowq_flowid = 8'(5 + i);
      #1;
      checks++; if (flowq_setup_rdy !== 1'b1) begin errors++; $display("FAIL setup_rdy[%0d] got=%b exp=1", i, flowq_setup_rdy); end
      step();
      if (i < 3) begin
        checks++; if (setup_done !== 1'b0) begin errors++; $display("FAIL setup_done_early[%0d] got=%b exp=0", i, setup_done); end
      end
    end
    checks++; if (setup_done !== 1'b1) begin errors++; $display("FAIL setup_done got=%b exp=1", setup_done); end
    checks++; if (flowq_occupancy !== 4'd4) begin errors++; $display("FAIL setup_occ got=%0d exp=4", flowq_occupancy); end
    checks++; if (recv_q_rd_data !== 8'd5) begin errors++; $display("FAIL setup_head got=%0d exp=5", recv_q_rd_data); end
    setup_flowq_flowid = 8'd99;
    #1;
    checks++; if (flowq_setup_rdy !== 1'b0) begin errors++; $display("FAIL done_rdy got=%b exp=0", flowq_setup_rdy); end
    step();
    checks++; if (flowq_occupancy !== 4'd4) begin errors++; $display("FAIL done_ignore_occ got=%0d exp=4", flowq_occupancy); end
    setup_flowq_val = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    for (int i = 0; i < 12; i++) begin
      exp = 8'(5 + (i % 4));
      checks++; if (recv_q_rd_data !== exp) begin errors++; $display("FAIL rr_head[%0d] got=%0d exp=%0d", i, recv_q_rd_data, exp); end
      recv_q_rd_req = 1'b1;
      recv_q_wr_req = 1'b1;
      recv_q_wr_data = exp;
      step();
      checks++; if (flowq_occupancy !== 4'd4) begin errors++; $display("FAIL rr_occ[%0d] got=%0d exp=4", i, flowq_occupancy); end
    end
    recv_q_rd_req = 1'b0;
    recv_q_wr_req = 1'b0;
  endtask

  task automatic test_setup_priority();
    logic [7:0] exp_ord [4];
    exp_ord = '{8'd5, 8'd6, 8'd9, 8'd3};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      setup_flowq_val = 1'b1;
      setup_flowq_flowid = 8'(5 + i);
      step();
    end
    recv_q_wr_req = 1'b1;
    recv_q_wr_data = 8'd9;
    setup_flowq_flowid = 8'd3;
    #1;
    checks++; if (flowq_setup_rdy !== 1'b0) begin errors++; $display("FAIL prio_rdy got=%b exp=0", flowq_setup_rdy); end
    step();
    recv_q_wr_req = 1'b0;
    checks++; if (flowq_occupancy !== 4'd3) begin errors++; $display("FAIL prio_occ3 got=%0d exp=3", flowq_occupancy); end
    #1;
    checks++; if (flowq_setup_rdy !== 1'b1) begin errors++; $display("FAIL prio_rdy_next got=%b exp=1", flowq_setup_rdy); end
    step();
    setup_flowq_val = 1'b0;
    checks++; if (flowq_occupancy !== 4'd4) begin errors++; $display("FAIL prio_occ4 got=%0d exp=4", flowq_occupancy); end
    checks++; if (setup_done !== 1'b0) begin errors++; $display("FAIL prio_done got=%b exp=0", setup_done); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (recv_q_rd_data !== exp_ord[i]) begin errors++; $display("FAIL prio_order[%0d] got=%0d exp=%0d", i, recv_q_rd_data, exp_ord[i]); end
      recv_q_rd_req = 1'b1;
      step();
      recv_q_rd_req = 1'b0;
      pops++;
    end
    checks++; if (recv_q_empty !== 1'b1) begin errors++; $display("FAIL prio_empty got=%b exp=1", recv_q_empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      recv_q_wr_req = 1'b1;
      recv_q_wr_data = 8'(10 + i);
      step();
    end
    recv_q_wr_req = 1'b0;
    checks++; if (recv_q_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", recv_q_full); end
    checks++; if (flowq_occupancy !== 4'd8) begin errors++; $display("FAIL ovf_occ8 got=%0d exp=8", flowq_occupancy); end
    checks++; if (recv_q_rd_data !== 8'd10) begin errors++; $display("FAIL ovf_head got=%0d exp=10", recv_q_rd_data); end
    recv_q_wr_req = 1'b1;
    recv_q_wr_data = 8'hEE;
    recv_q_rd_req = 1'b1;
    step();
    recv_q_wr_req = 1'b0;
    recv_q_rd_req = 1'b0;
    pops++;
    checks++; if (flowq_occupancy !== 4'd7) begin errors++; $display("FAIL ovf_occ7 got=%0d exp=7", flowq_occupancy); end
    checks++; if (recv_q_full !== 1'b0) begin errors++; $display("FAIL ovf_notfull got=%b exp=0", recv_q_full); end
`ifdef OPEN_LOOP_RX_FLOWQ_STATS_EN
    checks++; if (flowq_ovf !== 1'b1) begin errors++; $display("FAIL stats_ovf got=%b exp=1", flowq_ovf); end
    checks++; if (flowq_hwm !== 4'd8) begin errors++; $display("FAIL stats_hwm got=%0d exp=8", flowq_hwm); end
`endif
    for (int i = 0; i < 7; i++) begin
      checks++; if (recv_q_rd_data !== 8'(11 + i)) begin errors++; $display("FAIL ovf_drain[%0d] got=%0d exp=%0d", i, recv_q_rd_data, 11 + i); end
      recv_q_rd_req = 1'b1;
      step();
      recv_q_rd_req = 1'b0;
      pops++;
    end
    checks++; if (recv_q_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b exp=1", recv_q_empty); end
  endtask

  task automatic test_empty_rd_wr();
    recv_q_rd_req = 1'b1;
    recv_q_wr_req = 1'b1;
    recv_q_wr_data = 8'd2;
    step();
    recv_q_rd_req = 1'b0;
    recv_q_wr_req = 1'b0;
    checks++; if (recv_q_empty !== 1'b0) begin errors++; $display("FAIL erw_empty got=%b exp=0", recv_q_empty); end
    checks++; if (recv_q_rd_data !== 8'd2) begin errors++; $display("FAIL erw_head got=%0d exp=2", recv_q_rd_data); end
    checks++; if (flowq_occupancy !== 4'd1) begin errors++; $display("FAIL erw_occ got=%0d exp=1", flowq_occupancy); end
  endtask

  task automatic test_wrap();
    model.delete();
    model.push_back(8'd2);
    for (int i = 0; i < 2; i++) begin
      recv_q_wr_req = 1'b1;
      recv_q_wr_data = 8'(30 + i);
      step();
      model.push_back(8'(30 + i));
    end
    recv_q_wr_req = 1'b0;
    checks++; if (flowq_occupancy !== 4'd3) begin errors++; $display("FAIL wrap_occ_start got=%0d exp=3", flowq_occupancy); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (recv_q_rd_data !== model[0]) begin errors++; $display("FAIL wrap_head[%0d] got=%0d exp=%0d", i, recv_q_rd_data, model[0]); end
      recv_q_rd_req = 1'b1;
      recv_q_wr_req = 1'b1;
      recv_q_wr_data = 8'(20 + i);
      step();
      void'(model.pop_front());
      model.push_back(8'(20 + i));
      pops++;
      checks++; if (flowq_occupancy !== 4'd3) begin errors++; $display("FAIL wrap_occ[%0d] got=%0d exp=3", i, flowq_occupancy); end
    end
    recv_q_rd_req = 1'b0;
    recv_q_wr_req = 1'b0;
`ifdef OPEN_LOOP_RX_FLOWQ_STATS_EN
    checks++; if (flowq_pop_cnt !== 32'(pops)) begin errors++; $display("FAIL stats_pops got=%0d exp=%0d", flowq_pop_cnt, pops); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      setup_flowq_val = 1'b1;
      setup_flowq_flowid = 8'(1 + i);
      step();
    end
    setup_flowq_val = 1'b0;
    checks++; if (setup_done !== 1'b1) begin errors++; $display("FAIL mid_done_pre got=%b exp=1", setup_done); end
    recv_q_rd_req = 1'b1;
    step();
    recv_q_rd_req = 1'b0;
    checks++; if (flowq_occupancy !== 4'd3) begin errors++; $display("FAIL mid_occ_pre got=%0d exp=3", flowq_occupancy); end
    rst = 1'b1;
    #1;
    checks++; if (setup_done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", setup_done); end
    checks++; if (flowq_occupancy !== 4'd0) begin errors++; $display("FAIL mid_occ got=%0d exp=0", flowq_occupancy); end
    checks++; if (recv_q_empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", recv_q_empty); end
    checks++; if (recv_q_rd_data !== 8'd0) begin errors++; $display("FAIL mid_rd_data got=%0d exp=0", recv_q_rd_data); end
`ifdef OPEN_LOOP_RX_FLOWQ_STATS_EN
    checks++; if (flowq_hwm !== 4'd0) begin errors++; $display("FAIL mid_hwm got=%0d exp=0", flowq_hwm); end
`endif
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setup_flowq_val = 1'b1;
      setup_flowq_flowid = 8'(40 + i);
      #1;
      checks++; if (flowq_setup_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy[%0d] got=%b exp=1", i, flowq_setup_rdy); end
      step();
    end
    setup_flowq_val = 1'b0;
    checks++; if (setup_done !== 1'b1) begin errors++; $display("FAIL mid_done_post got=%b exp=1", setup_done); end
    checks++; if (flowq_occupancy !== 4'd4) begin errors++; $display("FAIL mid_occ_post got=%0d exp=4", flowq_occupancy); end
    checks++; if (recv_q_rd_data !== 8'd40) begin errors++; $display("FAIL mid_head_post got=%0d exp=40", recv_q_rd_data); end
  endtask

  initial begin
    test_reset();
    test_setup();
    test_round_robin();
    test_setup_priority();
    test_overflow();
    test_empty_rd_wr();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/open_loop_rx_flow_q.md
Name: open_loop_rx_flow_q

Overview:
Flow-ID work queue that sits directly upstream of the open-loop RX engine and drives its recv_q read/write ports and its setup_done input. During setup it accepts flow IDs from the app setup logic until NUM_FLOWS flows are registered, then asserts setup_done. After setup, the RX engine pops a flow ID, services it, and re-enqueues it, so flows are visited round-robin.

Parameters:
DEPTH, 64, queue capacity in entries; power of two, DEPTH >= 2.
NUM_FLOWS, 16, flows registered before setup_done; must satisfy 1 <= NUM_FLOWS <= DEPTH, otherwise elaboration error.
PTR_W, $clog2(DEPTH), read/write pointer width (derived).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
setup_flowq_val  in  1  setup logic presents a flow ID
setup_flowq_flowid  in  FLOWID_W  flow ID to register
flowq_setup_rdy  out  1  setup flow ID accepted this cycle
recv_q_empty  out  1  no entries available to read
recv_q_rd_data  out  FLOWID_W  head entry (first-word fall-through)
recv_q_rd_req  in  1  pop head
recv_q_full  out  1  no free entry
recv_q_wr_req  in  1  re-enqueue from RX engine
recv_q_wr_data  in  FLOWID_W  flow ID to re-enqueue
setup_done  out  1  sticky; NUM_FLOWS flows registered
flowq_occupancy  out  PTR_W+1  current entry count

Behaviour:
- Reset (async, active-high; clk and rst only):
  - rd_ptr = wr_ptr = 0, count = 0, reg_cnt = 0, state = SETUP.
  - Outputs: recv_q_empty = 1, recv_q_full = 0, setup_done = 0, flowq_setup_rdy = 0, flowq_occupancy = 0, recv_q_rd_data = 0.
  - Storage contents are don't-care.
- Storage: flop array of DEPTH x FLOWID_W.
  - recv_q_rd_data = mem[rd_ptr], combinational.
  - recv_q_rd_data is forced to 0 when empty.
- Flags are registered and derived from count:
  - recv_q_empty = (count == 0).
  - recv_q_full = (count == DEPTH).
  - No same-cycle bypass in either direction: a write to an empty queue is readable the next cycle; a read from a full queue frees a slot the next cycle.
- Read:
  - Effective when recv_q_rd_req && !recv_q_empty.
  - rd_ptr wraps modulo DEPTH.
  - rd_req while empty is ignored; no state change.
- Write sources: at most one write is accepted per cycle.
  - RX requeue has priority.
    - Accepted when recv_q_wr_req && !recv_q_full.
    - wr_req while full is dropped and sets an internal overflow flag, visible only under the optional feature.
  - Setup write:
    - flowq_setup_rdy = (state == SETUP) && !recv_q_full && !recv_q_wr_req.
    - The flow ID is accepted on setup_flowq_val && flowq_setup_rdy.
- Write pointer: wr_ptr wraps modulo DEPTH.
- Count: count_next = count + wr_accept - rd_accept.
  - Simultaneous read and write with count unchanged is legal, including when count == 1.
- FSM:
  - SETUP -> DONE on the cycle the NUM_FLOWS-th setup write is accepted (reg_cnt == NUM_FLOWS-1 && accept).
  - setup_done is registered high from the next cycle and stays high until reset.
  - DONE: flowq_setup_rdy = 0; setup_flowq_val is ignored.
  - No transition back to SETUP except via rst.
- Pre-setup traffic: the RX engine holds off reads until setup_done. Reads and requeues during SETUP are still honoured exactly as specified above.
- Reset mid-operation: all queued IDs are discarded, setup_done drops immediately (asynchronously), and the FSM restarts in SETUP.
- flowq_occupancy = count (registered).

Optional Feature:
Macro OPEN_LOOP_RX_FLOWQ_STATS_EN.
- Defined: adds three output ports, all reset to 0 and saturating at their maximum value.
  - flowq_hwm (PTR_W+1): highest count seen since reset.
  - flowq_pop_cnt (32): number of accepted reads.
  - flowq_ovf (1): sticky; set by a requeue write dropped while full.
- Undefined: these ports and their registers do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset then setup, NUM_FLOWS=4, DEPTH=8; present IDs 5,6,7,8 back-to-back with val=1.
  - Expect rdy high for 4 cycles and setup_done = 1 one cycle after the 4th accept.
  - Expect occupancy = 4, head = 5.
  - Expect rdy = 0 afterwards, even with val held.
- After setup, RX engine pops and re-enqueues the same ID in the same cycle, repeated 12 times.
  - Expect the head sequence 5,6,7,8,5,6,7,8,... and occupancy constant at 4.
- During SETUP with count=2, assert recv_q_wr_req (ID 9) and setup_flowq_val (ID 3) together.
  - Expect ID 9 enqueued, flowq_setup_rdy = 0, ID 3 accepted on the following cycle.
  - Expect order ...,9,3.
- Fill to DEPTH=8; then assert wr_req and rd_req in the same cycle.
  - Expect the read to succeed and the write to be dropped; count becomes 7.
  - With STATS_EN, expect flowq_ovf = 1 and flowq_hwm = 8.
- Empty queue: assert rd_req together with wr_req (ID 2).
  - Expect the read ignored, empty deasserted next cycle, and head = 2.
  - Pointer wrap: 20 pop/push pairs with DEPTH=8 return IDs in FIFO order.
- Assert rst mid-stream with count=3 after setup_done.
  - Expect setup_done, count and occupancy = 0 and empty = 1 immediately.
  - Expect a new setup sequence of 4 IDs to complete normally.
